video_ts_dram_arb: RTL and testbench
====================================

# video_ts_dram_arb

Burst-granular arbiter that shares the single video DRAM read port between three requesters. The requesters, in fixed priority order, are:
- bitmap fetch (VID);
- tilemap prefetch in video_ts (TM);
- tile/sprite renderer graphics fetch (TSR).

It sits between those requesters and the DRAM controller's video port. It routes the controller's per-word `next` strobe back to the current owner, and it guarantees that TSR is not starved by back-to-back TM bursts.

## Interface
Parameters:
- BURST, 8, maximum words per grant before re-arbitration (power of 2, 2..16).
- MAX_STREAK, 2, consecutive TM grants allowed while TSR is waiting (1..7).
- AW, 21, DRAM word address width.

Ports:
- clk  in  1  video clock.
- rst  in  1  asynchronous, active-high reset.
- vid_req  in  1  bitmap fetch request.
- vid_addr  in  AW  bitmap word address.
- vid_next  out  1  word for VID valid on mem_rdata / advance VID address.
- tm_req  in  1  tilemap prefetch request.
- tm_addr  in  AW  tilemap word address.
- tm_next  out  1  word for TM valid.
- tsr_req  in  1  renderer request.
- tsr_addr  in  AW  renderer word address.
- tsr_next  out  1  word for TSR valid.
- mem_req  out  1  request to DRAM controller.
- mem_addr  out  AW  address of the current word.
- mem_next  in  1  controller accepted and returned one word this cycle.
- own  out  2  current owner: 0 none, 1 VID, 2 TM, 3 TSR (debug/observability).

## Operation
- Owner register `own` plus burst counter `cnt` (log2(BURST) bits) and TM streak counter `streak` (3 bits).
- mem_req = req of owner (0 when own = none); mem_addr = addr of owner, else 0.
- x_next = mem_next && own == x. Non-owners never see next.
- Re-arbitration happens in a cycle where any of the following holds:
  - own = none;
  - owner req is low;
  - mem_next && cnt == BURST-1.
- In all other cycles own and cnt hold. Mid-burst preemption is never allowed, even by VID.
- Winner at re-arbitration:
  - VID if vid_req.
  - Else TSR if tsr_req and (streak == MAX_STREAK or !tm_req).
  - Else TM if tm_req.
  - Else TSR if tsr_req.
  - Else none.
- On re-arbitration, cnt is cleared to 0. Otherwise cnt increments on mem_next, wrapping modulo BURST.
- streak:
  - +1 (saturating at 7) when TM wins while tsr_req is high;
  - cleared when TSR wins or when tsr_req is low at re-arbitration;
  - unchanged by VID grants.
- The owner may drop req early; the grant ends that cycle with no word lost, because next only fires with mem_req high.
- mem_next while own = none or owner req low is a controller protocol error. It is ignored: no x_next fires and cnt is unchanged.

## Timing
- Reset values: own = 0, cnt = 0, streak = 0, mem_req = 0, mem_addr = 0, all x_next = 0.
- own is registered. A winner chosen in cycle N drives mem_req in cycle N+1.
- Burst-end handover (mem_next on the last word) has zero bubble: the new owner's mem_req is high in the very next cycle.
- Handover caused by owner req dropping costs one cycle with mem_req = 0.
- From idle, first mem_req is 1 cycle after the requester raises req.
- x_next is combinational from mem_next (same cycle), matching the dram_next → dram_rdata capture used by video_ts.
- A simultaneous burst end and a new higher-priority request resolves to the higher priority in the same re-arbitration.
- Reset asserted mid-burst returns all state to reset values immediately. No x_next is generated while rst is high.

## Structure
- Shared video package holds:
  - owner encoding constants OWN_NONE/OWN_VID/OWN_TM/OWN_TSR;
  - default BURST and MAX_STREAK.
- One natural sub-module: video_ts_arb_pick, a purely combinational winner selector (reqs, streak → winner). It is kept separate so it can be unit-checked exhaustively.
- The rest (own/cnt/streak registers, muxes, next routing) lives in the top module.

## Test plan
- TM alone, tm_req held, mem_next every cycle → own=TM, 8 tm_next pulses per grant, cnt wraps 7→0, no idle cycles between grants.
- TM and TSR both held, MAX_STREAK=2 → grant sequence TM,TM,TSR,TM,TM,TSR…; each TSR grant resets streak to 0.
- VID raised at word 3 of a TM burst → TM completes words 3..7, VID owns the next cycle after the 8th mem_next, TM resumes after VID drops.
- TSR drops tsr_req after 5 words → one cycle with mem_req=0, then the next waiting requester owns; exactly 5 tsr_next pulses were issued.
- Spurious mem_next with own=none, and rst asserted mid-burst → no x_next; after rst, own=0, cnt=0, streak=0, mem_req=0 asynchronously.
- Random req/mem_next stress with a scoreboard → every mem_next maps to exactly one x_next, mem_addr always equals the owner's addr, no grant exceeds BURST words.

Source files
------------

// File: rtl/video_ts_dram_arb_pkg.sv
// Shared video definitions for the DRAM read-port arbiter: owner encoding
// and default burst / streak parameters.
package video_ts_dram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_TM   = 2'd2,
        OWN_TSR  = 2'd3
    } own_t;

    localparam int DEFAULT_BURST      = 8;
    localparam int DEFAULT_MAX_STREAK = 2;
    localparam int STREAK_W           = 3;

endpackage

// File: rtl/video_ts_dram_arb_if.sv
// Bundle of requester handshakes and the DRAM controller video port, seen
// from the arbiter (slave) and from the requesters/controller (master).
interface video_ts_dram_arb_if #(
    parameter int AW = 21
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_next;
    logic          tm_req;
    logic [AW-1:0] tm_addr;
    logic          tm_next;
    logic          tsr_req;
    logic [AW-1:0] tsr_addr;
    logic          tsr_next;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_next;

    modport slave (
        input  vid_req, vid_addr, tm_req, tm_addr, tsr_req, tsr_addr, mem_next,
        output vid_next, tm_next, tsr_next, mem_req, mem_addr
    );

    modport master (
        output vid_req, vid_addr, tm_req, tm_addr, tsr_req, tsr_addr, mem_next,
        input  vid_next, tm_next, tsr_next, mem_req, mem_addr
    );
endinterface

// File: rtl/video_ts_arb_pick.sv
// Purely combinational winner selector: fixed priority VID > TM > TSR, except
// that TSR jumps ahead of TM once TM has used up its streak allowance.
module video_ts_arb_pick
    import video_ts_dram_arb_pkg::*;
#(
    parameter int MAX_STREAK = DEFAULT_MAX_STREAK
) (
    input  logic                vid_req,
    input  logic                tm_req,
    input  logic                tsr_req,
    input  logic [STREAK_W-1:0] streak,
    output own_t                winner
);

    always_comb begin
        winner = OWN_NONE;
        if (vid_req)
            winner = OWN_VID;
        else if (tsr_req && (streak == STREAK_W'(MAX_STREAK) || !tm_req))
            winner = OWN_TSR;
        else if (tm_req)
            winner = OWN_TM;
        else if (tsr_req)
            winner = OWN_TSR;
    end

endmodule

// File: rtl/video_ts_dram_arb.sv
// Burst-granular arbiter sharing the video DRAM read port between bitmap
// fetch, tilemap prefetch and the tile/sprite renderer.
module video_ts_dram_arb
    import video_ts_dram_arb_pkg::*;
#(
    parameter int BURST      = DEFAULT_BURST,
    parameter int MAX_STREAK = DEFAULT_MAX_STREAK,
    parameter int AW         = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    video_ts_dram_arb_if.slave    bus,
    output logic [1:0]            own
);

    localparam int CW = $clog2(BURST);

    own_t                own_q;
    own_t                winner;
    logic [CW-1:0]       cnt;
    logic [STREAK_W-1:0] streak;
    logic                owner_req;
    logic [AW-1:0]       owner_addr;
    logic                word_ok;
    logic                rearb;

    video_ts_arb_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .vid_req (bus.vid_req),
        .tm_req  (bus.tm_req),
        .tsr_req (bus.tsr_req),
        .streak  (streak),
        .winner  (winner)
    );

    always_comb begin
        owner_req  = 1'b0;
        owner_addr = '0;
        case (own_q)
            OWN_VID: begin
                owner_req  = bus.vid_req;
                owner_addr = bus.vid_addr;
            end
            OWN_TM: begin
                owner_req  = bus.tm_req;
                owner_addr = bus.tm_addr;
            end
            OWN_TSR: begin
                owner_req  = bus.tsr_req;
                owner_addr = bus.tsr_addr;
            end
            default: ;
        endcase
    end

    // A word only counts while the owner is actually requesting; stray
    // controller strobes and anything during reset are dropped here.
    assign word_ok = bus.mem_next && owner_req && !rst;
    assign rearb   = (own_q == OWN_NONE) || !owner_req ||
                     (bus.mem_next && cnt == CW'(BURST - 1));

    assign bus.mem_req  = owner_req;
    assign bus.mem_addr = owner_addr;
    assign bus.vid_next = word_ok && (own_q == OWN_VID);
    assign bus.tm_next  = word_ok && (own_q == OWN_TM);
    assign bus.tsr_next = word_ok && (own_q == OWN_TSR);
    assign own          = own_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q <= OWN_NONE;
            cnt   <= '0;
        end else if (rearb) begin
            own_q <= winner;
            cnt   <= '0;
        end else if (word_ok) begin
            cnt   <= cnt + 1'b1;
        end
    end

    // Streak counts TM grants taken while TSR is left waiting; VID grants
    // leave it alone so TSR keeps its claim across a bitmap burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (rearb) begin
            if (!bus.tsr_req || winner == OWN_TSR)
                streak <= '0;
            else if (winner == OWN_TM && streak != '1)
                streak <= streak + 1'b1;
        end
    end

endmodule

// File: tb/tb_video_ts_dram_arb.sv
// Directed-vector and stress bench for the video DRAM arbiter (BURST=8,
// MAX_STREAK=2).
module tb_video_ts_dram_arb;
    import video_ts_dram_arb_pkg::*;

    localparam int AW    = 21;
    localparam int BURST = 8;
    localparam logic [AW-1:0] VID_A = 21'h01000;
    localparam logic [AW-1:0] TM_A  = 21'h02000;
    localparam logic [AW-1:0] TSR_A = 21'h03000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] own;
    int         errors = 0;
    int         checks = 0;

    video_ts_dram_arb_if #(.AW(AW)) bus();

    video_ts_dram_arb #(
        .BURST      (BURST),
        .MAX_STREAK (2),
        .AW         (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .own (own)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vid;
        logic       tm;
        logic       tsr;
        logic       mn;
        logic [1:0] own;
        logic       mreq;
        logic [2:0] nexts;
    } vec_t;

    vec_t vecs[$];

    task automatic applyStimulus(input logic vid, input logic tm, input logic tsr, input logic mn);
        @(negedge clk);
        bus.vid_req  = vid;
        bus.tm_req   = tm;
        bus.tsr_req  = tsr;
        bus.mem_next = mn;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] ownerAddr(input logic [1:0] o);
        case (o)
            2'd1:    return bus.vid_addr;
            2'd2:    return bus.tm_addr;
            2'd3:    return bus.tsr_addr;
            default: return '0;
        endcase
    endfunction

    function automatic logic reqOf(input logic [1:0] o);
        case (o)
            2'd1:    return bus.vid_req;
            2'd2:    return bus.tm_req;
            2'd3:    return bus.tsr_req;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] o);
        case (o)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] nextsNow();
        return {bus.vid_next, bus.tm_next, bus.tsr_next};
    endfunction

    task automatic checkAll(input string tag, input logic [1:0] exp_own, input logic exp_req,
                            input logic [2:0] exp_nexts);
        checkOutput({tag, " own"}, 32'(own), 32'(exp_own));
        checkOutput({tag, " mem_req"}, 32'(bus.mem_req), 32'(exp_req));
        checkOutput({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(ownerAddr(exp_own)));
        checkOutput({tag, " nexts"}, 32'(nextsNow()), 32'(exp_nexts));
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.vid_req  = 1'b0;
        bus.tm_req   = 1'b0;
        bus.tsr_req  = 1'b0;
        bus.mem_next = 1'b0;
        bus.vid_addr = VID_A;
        bus.tm_addr  = TM_A;
        bus.tsr_addr = TSR_A;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void addVec(input logic vid, input logic tm, input logic tsr, input logic mn,
                                   input logic [1:0] o, input logic mreq, input logic [2:0] nx);
        vec_t v;
        v.vid = vid; v.tm = tm; v.tsr = tsr; v.mn = mn;
        v.own = o; v.mreq = mreq; v.nexts = nx;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [1:0] pat_own[3];
        int         pat_streak[3];
        int         tsr_words;
        logic [1:0] prev_own;
        logic [1:0] o;
        logic       exp_req;
        logic [2:0] exp_nx;
        logic       prev_rearb;
        bit         first;
        int         words;
        logic       vr, tr, sr;

        pat_own    = '{2'd2, 2'd2, 2'd3};
        pat_streak = '{1, 2, 0};

        // Idle, spurious strobe, TM burst with VID waiting, VID handover,
        // VID drop bubble, TM drop to TSR, TSR drop to idle.
        addVec(0,0,0,0, 2'd0,0,3'b000);
        addVec(0,0,0,1, 2'd0,0,3'b000);
        addVec(0,1,0,0, 2'd0,0,3'b000);
        addVec(0,1,0,1, 2'd2,1,3'b010);
        addVec(1,1,0,1, 2'd2,1,3'b010);
        addVec(1,1,0,0, 2'd2,1,3'b000);
        for (int i = 0; i < 5; i++) addVec(1,1,0,1, 2'd2,1,3'b010);
        addVec(1,1,0,1, 2'd2,1,3'b010);
        addVec(1,1,0,1, 2'd1,1,3'b100);
        addVec(0,1,0,1, 2'd1,0,3'b000);
        addVec(0,1,1,0, 2'd2,1,3'b000);
        addVec(0,0,1,1, 2'd2,0,3'b000);
        addVec(0,0,1,1, 2'd3,1,3'b001);
        addVec(0,0,1,0, 2'd3,1,3'b000);
        addVec(0,0,0,0, 2'd3,0,3'b000);
        addVec(0,0,0,0, 2'd0,0,3'b000);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].vid, vecs[i].tm, vecs[i].tsr, vecs[i].mn);
            checkAll($sformatf("vec%0d", i), vecs[i].own, vecs[i].mreq, vecs[i].nexts);
        end

        // TM and TSR both held with a word every cycle: TM,TM,TSR rotation.
        doReset();
        applyStimulus(0, 1, 1, 1);
        checkAll("streak idle", 2'd0, 1'b0, 3'b000);
        for (int k = 0; k < 48; k++) begin
            applyStimulus(0, 1, 1, 1);
            checkOutput($sformatf("streak own w%0d", k), 32'(own), 32'(pat_own[(k / 8) % 3]));
            checkOutput($sformatf("streak nexts w%0d", k), 32'(nextsNow()),
                        32'(onehot(pat_own[(k / 8) % 3])));
            if (k % 8 == 0)
                checkOutput($sformatf("streak value w%0d", k), 32'(dut.streak),
                            32'(pat_streak[(k / 8) % 3]));
        end

        // TSR drops its request after 5 words while TM waits.
        doReset();
        applyStimulus(0, 0, 1, 0);
        checkAll("drop idle", 2'd0, 1'b0, 3'b000);
        tsr_words = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 1, 1);
            if (bus.tsr_next) tsr_words++;
        end
        checkOutput("drop tsr words", 32'(tsr_words), 32'd5);
        applyStimulus(0, 1, 0, 1);
        checkAll("drop bubble", 2'd3, 1'b0, 3'b000);
        applyStimulus(0, 1, 0, 0);
        checkAll("drop next owner", 2'd2, 1'b1, 3'b000);

        // Reset asserted in the middle of a TM burst with a word pending.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 1);
        checkAll("midrst pre", 2'd2, 1'b1, 3'b010);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAll("midrst async", 2'd0, 1'b0, 3'b000);
        checkOutput("midrst cnt", 32'(dut.cnt), 32'd0);
        checkOutput("midrst streak", 32'(dut.streak), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_next = 1'b0;
        #1;
        checkAll("midrst release", 2'd0, 1'b0, 3'b000);
        applyStimulus(0, 1, 0, 0);
        checkAll("midrst regrant", 2'd2, 1'b1, 3'b000);

        // Random stress: routing, address mux and no mid-burst ownership change.
        doReset();
        vr = 1'b0; tr = 1'b0; sr = 1'b0;
        first = 1'b1; words = 0; prev_rearb = 1'b0; prev_own = 2'd0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(15) == 0) vr = ~vr;
            if ($urandom_range(11) == 0) tr = ~tr;
            if ($urandom_range(11) == 0) sr = ~sr;
            applyStimulus(vr, tr, sr, $urandom_range(3) != 0);
            bus.vid_addr = AW'($urandom);
            bus.tm_addr  = AW'($urandom);
            bus.tsr_addr = AW'($urandom);
            #1;
            o       = own;
            exp_req = reqOf(o);
            exp_nx  = (exp_req && bus.mem_next) ? onehot(o) : 3'b000;
            checkOutput("stress mem_req", 32'(bus.mem_req), 32'(exp_req));
            checkOutput("stress mem_addr", 32'(bus.mem_addr), 32'(ownerAddr(o)));
            checkOutput("stress nexts", 32'(nextsNow()), 32'(exp_nx));
            if (!first && o != prev_own)
                checkOutput("stress preempt", 32'(prev_rearb), 32'd1);
            prev_rearb = (o == 2'd0) || !exp_req || (exp_nx != 3'b000 && words == BURST - 1);
            if (prev_rearb)
                words = 0;
            else if (exp_nx != 3'b000)
                words++;
            prev_own = o;
            first = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
